// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-cache fill, D-cache fill and writeback drain ports onto one lower-memory port.
// Latency: a request sampled in IDLE drives the memory port from the next cycle; resp is combinational with mem_resp.
// Backpressure: a requester waits, holding its request, until its resp pulse; one IDLE cycle separates transactions.
// Ports: clk/rst (sync, active-high); ic_* and dc_* line-fill ports; wb_* drain port; mem_* shared memory port.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ic_read,
  input  logic [31:0]  ic_addr,
  output logic [255:0] ic_rdata,
  output logic         ic_resp,
  input  logic         dc_read,
  input  logic [31:0]  dc_addr,
  output logic [255:0] dc_rdata,
  output logic         dc_resp,
  input  logic         wb_write,
  input  logic [31:0]  wb_addr,
  input  logic [255:0] wb_wdata,
  output logic         wb_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, SERVE_WB} state_t;

  // rr_last encoding: which read port won the most recent read grant.
  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Fill data is a plain passthrough; it is only meaningful alongside the resp pulse.
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign mem_wdata = wb_wdata;

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    ic_resp      = 1'b0;
    dc_resp      = 1'b0;
    wb_resp      = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_resp is deliberately not looked at here.
        if (wb_write && (starve_cnt_q >= LIMIT)) begin
          state_d = SERVE_WB;
        end else if (ic_read && dc_read) begin
          state_d = (rr_last_q == RR_I) ? SERVE_D : SERVE_I;
        end else if (ic_read) begin
          state_d = SERVE_I;
        end else if (dc_read) begin
          state_d = SERVE_D;
        end else if (wb_write) begin
          state_d = SERVE_WB;
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        mem_addr = ic_addr;
        if (mem_resp) begin
          ic_resp = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        mem_read = 1'b1;
        mem_addr = dc_addr;
        if (mem_resp) begin
          dc_resp = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_WB: begin
        mem_write = 1'b1;
        mem_addr  = wb_addr;
        if (mem_resp) begin
          wb_resp = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant bookkeeping happens only on the IDLE->SERVE_x edge.
    if (state_q == IDLE) begin
      case (state_d)
        SERVE_I: begin
          rr_last_d = RR_I;
          if (wb_write && (starve_cnt_q < LIMIT)) starve_cnt_d = starve_cnt_q + 4'd1;
        end
        SERVE_D: begin
          rr_last_d = RR_D;
          if (wb_write && (starve_cnt_q < LIMIT)) starve_cnt_d = starve_cnt_q + 4'd1;
        end
        SERVE_WB: starve_cnt_d = '0;
        default: ;
      endcase
    end

    // Starvation only accrues while a writeback is actually waiting.
    if (!wb_write) starve_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_last_q    <= RR_I;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of per-cycle vectors plus a starvation sequence.
module tb_mem_port_arbiter;

  localparam logic [31:0]  IC_A  = 32'h1000_0100;
  localparam logic [31:0]  DC_A  = 32'h0000_1240;
  localparam logic [31:0]  WB_A  = 32'h2000_0040;
  localparam logic [255:0] WB_WD = {8{32'hA5C3_0F1E}};

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_read, dc_read, wb_write, mem_resp;
  logic [31:0]  ic_addr, dc_addr, wb_addr;
  logic [255:0] wb_wdata, mem_rdata;
  logic [255:0] ic_rdata, dc_rdata, mem_wdata;
  logic         ic_resp, dc_resp, wb_resp, mem_read, mem_write;
  logic [31:0]  mem_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_read(dc_read), .dc_addr(dc_addr), .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_resp(wb_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // exp bits: {mem_read, mem_write, ic_resp, dc_resp, wb_resp}; sel: 0 none, 1 I, 2 D, 3 WB.
  typedef struct {
    logic       rst;
    logic       ic;
    logic       dc;
    logic       wb;
    logic       resp;
    logic [4:0] exp;
    int         sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic i, input logic d, input logic w,
                     input logic m, input logic [4:0] e, input int s);
    vec_t v;
    v.rst = r; v.ic = i; v.dc = d; v.wb = w; v.resp = m; v.exp = e; v.sel = s;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ctrl();
    return {mem_read, mem_write, ic_resp, dc_resp, wb_resp};
  endfunction

  initial begin
    logic [31:0] exp_addr;
    int   rd_grants;
    int   wb_seen;
    int   viol;
    int   grants_before[2];
    logic want_ic;

    // Reset-state row (IDLE after reset with nothing requesting).
    add(0,0,0,0,0,5'b00000,0);
    // Both reads right after reset: D first, then I.
    add(0,1,1,0,0,5'b00000,0);
    add(0,1,1,0,0,5'b10000,2);
    add(0,1,1,0,1,5'b10010,2);
    add(0,1,0,0,0,5'b00000,0);
    add(0,1,0,0,1,5'b10100,1);
    add(0,0,0,0,0,5'b00000,0);
    // Single dc_read, mem_resp in the 5th serve cycle.
    add(0,0,1,0,0,5'b00000,0);
    for (int k = 0; k < 4; k++) add(0,0,1,0,0,5'b10000,2);
    add(0,0,1,0,1,5'b10010,2);
    add(0,0,0,0,0,5'b00000,0);
    // Writeback only, 3 cycles of mem_write.
    add(0,0,0,1,0,5'b00000,0);
    add(0,0,0,1,0,5'b01000,3);
    add(0,0,0,1,0,5'b01000,3);
    add(0,0,0,1,1,5'b01001,3);
    add(0,0,0,0,0,5'b00000,0);
    // mem_resp in IDLE is ignored, then a normal ic fill.
    add(0,0,0,0,1,5'b00000,0);
    add(0,0,0,0,1,5'b00000,0);
    add(0,1,0,0,0,5'b00000,0);
    add(0,1,0,0,1,5'b10100,1);
    add(0,0,0,0,0,5'b00000,0);
    // Both reads held through resp: re-requests alternate D, I, D.
    add(0,1,1,0,0,5'b00000,0);
    add(0,1,1,0,1,5'b10010,2);
    add(0,1,1,0,0,5'b00000,0);
    add(0,1,1,0,1,5'b10100,1);
    add(0,1,1,0,0,5'b00000,0);
    add(0,0,1,0,1,5'b10010,2);
    add(0,0,0,0,0,5'b00000,0);
    // Read beats a non-starved writeback, then the writeback runs.
    add(0,1,0,1,0,5'b00000,0);
    add(0,1,0,1,1,5'b10100,1);
    add(0,0,0,1,0,5'b00000,0);
    add(0,0,0,1,1,5'b01001,3);
    add(0,0,0,0,0,5'b00000,0);
    // dc fill so rr_last=D, then reset in the 2nd cycle of an I fill.
    add(0,0,1,0,0,5'b00000,0);
    add(0,0,1,0,1,5'b10010,2);
    add(0,1,0,0,0,5'b00000,0);
    add(0,1,0,0,0,5'b10000,1);
    add(1,1,0,0,0,5'b10000,1);
    add(0,0,0,0,1,5'b00000,0);
    add(0,0,0,0,1,5'b00000,0);
    // rr_last back to I after reset: D wins the tie.
    add(0,1,1,0,0,5'b00000,0);
    add(0,1,1,0,1,5'b10010,2);
    add(0,0,0,0,0,5'b00000,0);

    rst = 1'b1; ic_read = 0; dc_read = 0; wb_write = 0; mem_resp = 0;
    ic_addr = IC_A; dc_addr = DC_A; wb_addr = WB_A; wb_wdata = WB_WD;
    mem_rdata = '0;
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; ic_read = vecs[i].ic; dc_read = vecs[i].dc;
      wb_write = vecs[i].wb; mem_resp = vecs[i].resp;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #1;
      check($sformatf("row%0d_ctrl", i), 256'(ctrl()), 256'(vecs[i].exp));
      if (vecs[i].sel != 0) begin
        exp_addr = (vecs[i].sel == 1) ? IC_A : (vecs[i].sel == 2) ? DC_A : WB_A;
        check($sformatf("row%0d_addr", i), 256'(mem_addr), 256'(exp_addr));
      end
      if (vecs[i].sel == 3) check($sformatf("row%0d_wdata", i), mem_wdata, WB_WD);
      if (vecs[i].exp[2]) check($sformatf("row%0d_ic_rdata", i), ic_rdata, mem_rdata);
      if (vecs[i].exp[1]) check($sformatf("row%0d_dc_rdata", i), dc_rdata, mem_rdata);
    end

    // Starvation: writeback held while reads alternate; expect 8 read grants
    // before each writeback grant (the second run shows the counter restarted).
    rd_grants = 0; wb_seen = 0; viol = 0; want_ic = 1'b1;
    grants_before[0] = -1; grants_before[1] = -1;
    for (int cyc = 0; cyc < 400 && wb_seen < 2; cyc++) begin
      @(negedge clk);
      rst = 1'b0; wb_write = 1'b1; ic_read = want_ic; dc_read = !want_ic; mem_resp = 1'b0;
      #1;
      if (mem_read || mem_write) mem_resp = 1'b1;
      #1;
      if ((int'(ic_resp) + int'(dc_resp) + int'(wb_resp)) > 1 || (mem_read && mem_write)) viol++;
      if (ic_resp || dc_resp) begin
        rd_grants++;
        want_ic = !want_ic;
      end
      if (wb_resp) begin
        grants_before[wb_seen] = rd_grants;
        rd_grants = 0;
        wb_seen++;
      end
    end
    check("starve_wb_grants_seen", 256'(wb_seen), 256'(2));
    check("starve_reads_before_wb0", 256'(grants_before[0]), 256'(8));
    check("starve_reads_before_wb1", 256'(grants_before[1]), 256'(8));
    check("exclusive_outputs", 256'(viol), 256'(0));

    @(negedge clk);
    wb_write = 0; ic_read = 0; dc_read = 0; mem_resp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 8, number of read grants a pending writeback may lose before it is forced to win (legal range 1-15).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: ic_read  input  1 / ic_addr  input  32 / ic_rdata  output  256 / ic_resp  output  1  (I-cache line-fill port).
REQ-005 SHALL have ports: dc_read  input  1 / dc_addr  input  32 / dc_rdata  output  256 / dc_resp  output  1  (D-cache line-fill port).
REQ-006 SHALL have ports: wb_write  input  1 / wb_addr  input  32 / wb_wdata  input  256 / wb_resp  output  1  (eviction write buffer drain port).
REQ-007 SHALL have ports: mem_read  output  1 / mem_write  output  1 / mem_addr  output  32 / mem_wdata  output  256 / mem_rdata  input  256 / mem_resp  input  1  (single shared lower-memory port).

Function
REQ-008 SHALL implement states IDLE, SERVE_I, SERVE_D, SERVE_WB; exactly one state active at any time.
REQ-009 SHALL, in IDLE, drive mem_read=0, mem_write=0, and all *_resp=0.
REQ-010 SHALL, in IDLE, select the next state from the requests sampled that cycle, in this priority order:
- wb_write=1 and starve_cnt>=STARVE_LIMIT -> SERVE_WB.
- ic_read=1 and dc_read=1 -> the read port not recorded in rr_last.
- Exactly one of ic_read/dc_read=1 -> that port.
- Only wb_write=1 -> SERVE_WB.
- No request -> stay in IDLE.
REQ-011 SHALL, in SERVE_I, drive mem_read=1, mem_write=0, mem_addr=ic_addr.
REQ-012 SHALL, in SERVE_D, drive mem_read=1, mem_write=0, mem_addr=dc_addr.
REQ-013 SHALL, in SERVE_WB, drive mem_write=1, mem_read=0, mem_addr=wb_addr, mem_wdata=wb_wdata.
REQ-014 SHALL, in each SERVE_x state, hold that state while mem_resp=0.
REQ-015 SHALL, in SERVE_x with mem_resp=1, pulse x_resp=1 combinationally in the same cycle and transition to IDLE.
REQ-016 SHALL drive ic_rdata and dc_rdata continuously equal to mem_rdata; data is valid only in the cycle the matching resp is high.
REQ-017 SHALL never assert more than one of ic_resp, dc_resp, wb_resp in the same cycle, and never assert mem_read and mem_write together.
REQ-018 SHALL insert one IDLE cycle between back-to-back transactions, so a granted request sees mem_read/mem_write asserted starting the cycle after the IDLE sample.
REQ-019 SHALL update rr_last to I or D on entering SERVE_I or SERVE_D respectively; rr_last SHALL be unchanged on entering SERVE_WB.
REQ-020 SHALL keep starve_cnt with these update rules:
- Increment on each IDLE->SERVE_I or IDLE->SERVE_D transition taken while wb_write=1, saturating at STARVE_LIMIT.
- Clear to 0 on IDLE->SERVE_WB.
- Clear to 0 in any cycle with wb_write=0.
REQ-021 SHALL ignore mem_resp while in IDLE (no resp output, no state change).
REQ-022 SHALL not depend on requesters deasserting after resp; a request still high in the following IDLE cycle is treated as a new request.
REQ-023 SHALL not abort a SERVE_x state when its requester drops its request; that is a protocol violation and its behaviour is unspecified.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, set state=IDLE, rr_last=I, and starve_cnt=0, overriding all other transitions, including a transaction in progress.
REQ-025 SHALL, as a result, have all outputs at their IDLE values the cycle after reset: mem_read=0, mem_write=0, every resp=0.

Verification
REQ-026 SHALL cover: after reset, ic_read and dc_read both high -> SERVE_D first (rr_last=I), then SERVE_I after dc_resp.
REQ-027 SHALL cover: single dc_read at A=0x0000_1240 with mem_resp after 5 cycles -> mem_read=1 and mem_addr=0x0000_1240 from cycle 1 through cycle 5; dc_resp=1 in cycle 5 only; dc_rdata=mem_rdata in that cycle.
REQ-028 SHALL cover: wb_write held high while ic_read/dc_read continuously alternate, STARVE_LIMIT=8 -> SERVE_WB granted after exactly 8 read grants; starve_cnt=0 afterwards.
REQ-029 SHALL cover: wb_write only, mem_resp after 3 cycles -> mem_write=1 with wb_addr/wb_wdata for 3 cycles, wb_resp pulse, return to IDLE; mem_read stays 0 throughout.
REQ-030 SHALL cover: rst asserted in cycle 2 of SERVE_I -> mem_read=0 and ic_resp=0 the next cycle; a subsequent mem_resp in IDLE produces no resp.
REQ-031 SHALL cover: mem_resp=1 while in IDLE with no requests -> all resp outputs stay 0 and state stays IDLE.
